// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared FIFO defaults, operation struct and pointer helper
package shared_pkg;

  localparam int FIFO_DEF_WIDTH = 16;
  localparam int FIFO_DEF_DEPTH = 8;

  typedef struct packed {
    logic wr_acc;
    logic rd_acc;
  } fifo_op_t;

  // Circular increment for depths that need not be a power of two.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parameterised single-clock FIFO with status flags
// Pointer, occupancy and flag logic; storage lives in fifo_mem.
module fifo_sync_param
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH      = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (!(DEPTH >= 2 && AE_LEVEL >= 1 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH - 1)) begin : g_bad_params
    $error("fifo_sync_param: need DEPTH>=2 and 1<=AE_LEVEL<AF_LEVEL<=DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  fifo_op_t              op;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    op.rd_acc = rd_en && (count_q != '0);
    op.wr_acc = wr_en && ((count_q < DEPTH_C) || op.rd_acc);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;

    // In FWFT mode the register shadows the head so data_out holds once empty.
    if (FWFT != 0 && count_q != '0) begin
      data_out_d = mem_rd_data;
    end

    if (!flush) begin
      wr_ack_d    = op.wr_acc;
      overflow_d  = wr_en && !op.wr_acc;
      underflow_d = rd_en && (count_q == '0);
      mem_we      = op.wr_acc && !rst;

      if (op.wr_acc) begin
        wr_ptr_d = PW'(ptr_next(int'(wr_ptr_q), DEPTH));
      end
      if (op.rd_acc) begin
        rd_ptr_d = PW'(ptr_next(int'(rd_ptr_q), DEPTH));
        if (FWFT == 0) begin
          data_out_d = mem_rd_data;
        end
      end

      case ({op.wr_acc, op.rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end else begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = (count_q != '0) ? mem_rd_data : data_out_q;
  end else begin : g_reg_read
    assign data_out = data_out_q;
  end

  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_C) && !full;
  assign almostempty = (count_q <= AE_C) && !empty;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed bench for fifo_sync_param
module tb_fifo_sync_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: W16 D8 AF6 AE2, registered read
  logic        a_rst, a_flush, a_wr, a_rd;
  logic [15:0] a_din, a_dout;
  logic        a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;

  // Instance B: W16 D6, registered read
  logic        b_rst, b_flush, b_wr, b_rd;
  logic [15:0] b_din, b_dout;
  logic        b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_cnt;

  // Instance C: W16 D8, first-word-fall-through
  logic        c_rst, c_flush, c_wr, c_rd;
  logic [15:0] c_din, c_dout;
  logic        c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
  logic [3:0]  c_cnt;

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .wr_ack(a_ack), .overflow(a_ovf),
    .underflow(a_udf), .full(a_full), .empty(a_empty), .almostfull(a_af),
    .almostempty(a_ae), .count(a_cnt)
  );

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(6), .FWFT(0)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .wr_ack(b_ack), .overflow(b_ovf),
    .underflow(b_udf), .full(b_full), .empty(b_empty), .almostfull(b_af),
    .almostempty(b_ae), .count(b_cnt)
  );

  fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(1)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush), .wr_en(c_wr), .data_in(c_din),
    .rd_en(c_rd), .data_out(c_dout), .wr_ack(c_ack), .overflow(c_ovf),
    .underflow(c_udf), .full(c_full), .empty(c_empty), .almostfull(c_af),
    .almostempty(c_ae), .count(c_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_flush, a_wr, a_rd, b_flush, b_wr, b_rd, c_flush, c_wr, c_rd} = '0;
    a_din = '0; b_din = '0; c_din = '0;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    check("rst_count", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_af", a_af, 0);
    check("rst_ae", a_ae, 0);
    check("rst_dout", a_dout, 0);
    check("rst_status", {a_ack, a_ovf, a_udf}, 0);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      a_wr = 1'b1; a_din = 16'(i);
      tick();
      check("fill_ack", a_ack, 1);
      check("fill_count", a_cnt, i);
      check("fill_af", a_af, (i == 6 || i == 7) ? 1 : 0);
      check("fill_full", a_full, (i == 8) ? 1 : 0);
      check("fill_ae", a_ae, (i <= 2) ? 1 : 0);
    end
    a_din = 16'h0009;
    tick();
    check("ovf_flag", a_ovf, 1);
    check("ovf_ack", a_ack, 0);
    check("ovf_count", a_cnt, 8);
    a_wr = 1'b0;

    // Drain
    for (int i = 1; i <= 8; i++) begin
      a_rd = 1'b1;
      tick();
      check("drain_dout", a_dout, i);
      check("drain_count", a_cnt, 8 - i);
    end
    check("drain_empty", a_empty, 1);
    tick();
    check("udf_flag", a_udf, 1);
    check("udf_dout_hold", a_dout, 16'h0008);
    a_rd = 1'b0;

    // Both asserted while empty: write only
    a_wr = 1'b1; a_rd = 1'b1; a_din = 16'h0055;
    tick();
    check("empty_both_count", a_cnt, 1);
    check("empty_both_udf", a_udf, 1);
    check("empty_both_ack", a_ack, 1);
    check("empty_both_dout", a_dout, 16'h0008);
    a_rd = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_din = 16'(16'h0056 + i);
      tick();
    end
    check("refill_full", a_full, 1);

    // Both asserted while full: both accepted
    a_rd = 1'b1; a_din = 16'h0077;
    tick();
    check("full_both_count", a_cnt, 8);
    check("full_both_ovf", a_ovf, 0);
    check("full_both_ack", a_ack, 1);
    check("full_both_dout", a_dout, 16'h0055);
    a_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("part_drain_dout", a_dout, 16'h0056 + i);
    end
    a_rd = 1'b0;
    check("part_drain_count", a_cnt, 4);

    // Flush beats write
    a_flush = 1'b1; a_wr = 1'b1; a_din = 16'h00EE;
    tick();
    check("flush_count", a_cnt, 0);
    check("flush_empty", a_empty, 1);
    check("flush_dout", a_dout, 16'h0059);
    check("flush_ack", a_ack, 0);
    a_flush = 1'b0;
    a_din = 16'h00AA; tick();
    a_din = 16'h00BB; tick();
    a_wr = 1'b0; a_rd = 1'b1;
    tick();
    check("post_flush_dout", a_dout, 16'h00AA);
    check("post_flush_count", a_cnt, 1);
    a_rd = 1'b0;

    // Reset mid-stream beats write
    a_rst = 1'b1; a_wr = 1'b1; a_din = 16'h00CC;
    tick();
    check("mid_rst_count", a_cnt, 0);
    check("mid_rst_dout", a_dout, 0);
    check("mid_rst_status", {a_ack, a_ovf, a_udf}, 0);
    check("mid_rst_flags", {a_full, a_af, a_ae, a_empty}, 4'b0001);
    a_rst = 1'b0; a_wr = 1'b0;

    // Wrap on DEPTH=6
    b_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_din = 16'(16'h0010 + i);
      tick();
    end
    b_wr = 1'b0; b_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wrap_rd1", b_dout, 16'h0010 + i);
    end
    b_rd = 1'b0; b_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_din = 16'(16'h0020 + i);
      tick();
    end
    b_wr = 1'b0;
    check("wrap_count6", b_cnt, 6);
    check("wrap_full", b_full, 1);
    b_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("wrap_rd2", b_dout, 16'h0020 + i);
    end
    b_rd = 1'b0;
    check("wrap_empty", b_empty, 1);

    // First-word-fall-through
    check("fwft_rst_dout", c_dout, 0);
    c_wr = 1'b1; c_din = 16'hA5A5;
    tick();
    c_wr = 1'b0;
    check("fwft_show", c_dout, 16'hA5A5);
    check("fwft_count", c_cnt, 1);
    tick();
    check("fwft_stable", c_dout, 16'hA5A5);
    c_rd = 1'b1;
    tick();
    c_rd = 1'b0;
    check("fwft_pop_empty", c_empty, 1);
    check("fwft_hold", c_dout, 16'hA5A5);
    c_wr = 1'b1; c_din = 16'h1111; tick();
    c_din = 16'h2222; tick();
    c_wr = 1'b0;
    check("fwft_head", c_dout, 16'h1111);
    c_rd = 1'b1;
    tick();
    check("fwft_next", c_dout, 16'h2222);
    tick();
    c_rd = 1'b0;
    check("fwft_last_empty", c_empty, 1);
    check("fwft_last_hold", c_dout, 16'h2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
